// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 codes, decode constants and FSM encodings.
package riscv_m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [6:0] FUNCT7_M  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    MULW = 2'd2,
    DONE = 2'd3
  } m_state_e;

  function automatic logic op1_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/m_iter_datapath.sv
// One MSB-first iteration: shift-add multiply step or restoring-divide step.
// acc layout for divide: [63:32] partial remainder, [31:0] quotient being shifted in.
module m_iter_datapath (
  input  logic [63:0] acc_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  bit_idx_i,
  input  logic        is_div_i,
  output logic [63:0] acc_o
);

  logic [32:0] shifted;
  logic        ge;
  logic [31:0] rem_sub;

  always_comb begin
    shifted = {acc_i[63:32], a_i[bit_idx_i]};
    ge      = shifted >= {1'b0, b_i};
    // when ge holds the true difference is below b_i, so 32 bits suffice
    rem_sub = shifted[31:0] - b_i;
    acc_o   = {acc_i[62:0], 1'b0} + (b_i[bit_idx_i] ? {32'b0, a_i} : 64'b0);
    if (is_div_i) begin
      if (ge) acc_o = {rem_sub, acc_i[30:0], 1'b1};
      else    acc_o = {shifted[31:0], acc_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/m_extension_unit.sv
// Multi-cycle RV32M execute unit (sign-magnitude iterative mul/div).
// FAST_MUL_EN: MUL family uses a single registered multiplier (IDLE->MULW->DONE).
module m_extension_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            ready,
  output logic            wr,
  output logic [4:0]      dest,
  output logic [XLEN-1:0] result
);

  m_state_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      a_q, b_q;
  logic [63:0]      acc_q, acc_d;
  logic [2:0]       f3_q;
  logic [4:0]       rd_q;
  logic             neg_q, rneg_q, divz_q;
  logic             busy_q, ready_q, wr_q;
  logic [4:0]       dest_q;
  logic [31:0]      result_q;

  logic [2:0]  f3_in;
  logic [4:0]  rd_in;
  logic        s1, s2, accept;
  logic [31:0] a_in, b_in;
  logic [63:0] fin_src, prod;
  logic [31:0] quo, rem, result_d;
  logic        unused_instr;

  assign unused_instr = ^{instruction[31:15], instruction[6:0]};

  always_comb begin
    f3_in  = instruction[14:12];
    rd_in  = instruction[11:7];
    s1     = op1[31] & op1_is_signed(f3_in);
    s2     = op2[31] & op2_is_signed(f3_in);
    a_in   = s1 ? -op1 : op1;
    b_in   = s2 ? -op2 : op2;
    accept = start && !flush && ((state_q == IDLE) || (state_q == DONE));
  end

  m_iter_datapath u_step (
    .acc_i     (acc_q),
    .a_i       (a_q),
    .b_i       (b_q),
    .bit_idx_i (cnt_q[4:0]),
    .is_div_i  (f3_q[2]),
    .acc_o     (acc_d)
  );

  // Sign correction of the final magnitude, valid in the cycle that enters DONE.
  always_comb begin
    fin_src = acc_d;
`ifdef FAST_MUL_EN
    if (state_q == MULW) fin_src = {32'b0, a_q} * {32'b0, b_q};
`endif
    prod = neg_q ? -fin_src : fin_src;
    quo  = divz_q ? 32'hFFFF_FFFF : (neg_q ? -fin_src[31:0] : fin_src[31:0]);
    rem  = rneg_q ? -fin_src[63:32] : fin_src[63:32];
    case (f3_q)
      F3_MUL:           result_d = prod[31:0];
      F3_DIV, F3_DIVU:  result_d = quo;
      F3_REM, F3_REMU:  result_d = rem;
      default:          result_d = prod[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      divz_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      wr_q     <= 1'b0;
      dest_q   <= '0;
      result_q <= '0;
    end else begin
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      if (accept) begin
        a_q    <= a_in;
        b_q    <= b_in;
        acc_q  <= '0;
        cnt_q  <= CNT_W'(XLEN - 1);
        f3_q   <= f3_in;
        rd_q   <= rd_in;
        neg_q  <= s1 ^ s2;
        rneg_q <= s1;
        divz_q <= (op2 == '0);
        busy_q <= 1'b1;
        state_q <= CALC;
`ifdef FAST_MUL_EN
        if (!f3_in[2]) state_q <= MULW;
`endif
      end else begin
        case (state_q)
          CALC: begin
            if (flush) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q - 1'b1;
              if (cnt_q == '0) begin
                state_q  <= DONE;
                ready_q  <= 1'b1;
                wr_q     <= (rd_q != 5'd0);
                dest_q   <= rd_q;
                result_q <= result_d;
              end
            end
          end
          MULW: begin
            if (flush) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= DONE;
              ready_q  <= 1'b1;
              wr_q     <= (rd_q != 5'd0);
              dest_q   <= rd_q;
              result_q <= result_d;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign ready  = ready_q;
  assign wr     = wr_q;
  assign dest   = dest_q;
  assign result = result_q;

endmodule

// File: tb/tb_m_extension_unit.sv
// Self-checking bench for m_extension_unit: directed RV32M corner cases plus random ops
// against an arithmetic reference model.
module tb_m_extension_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [31:0] instruction, op1, op2;
  logic        busy, ready, wr;
  logic [4:0]  dest;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  m_extension_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flush       (flush),
    .instruction (instruction),
    .op1         (op1),
    .op2         (op2),
    .busy        (busy),
    .ready       (ready),
    .wr          (wr),
    .dest        (dest),
    .result      (result)
  );

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Reference: plain 64-bit arithmetic plus the RISC-V special cases.
  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3);
`ifdef FAST_MUL_EN
    return f3[2] ? 33 : 2;
`else
    return (f3 == 3'd7) ? 33 : 33;
`endif
  endfunction

  // Start an op in cycle 0 and return at the negedge of the cycle where ready is seen.
  task automatic do_op(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output logic w,
                       output logic [4:0] d, output int lat);
    @(negedge clk);
    instruction = mk_instr(f3, rd);
    op1 = a;
    op2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    w   = wr;
    d   = dest;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    instruction = '0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (ready !== 1'b0)   begin n_bad++; $display("FAIL reset_ready got %b want 0", ready); end
    if (wr !== 1'b0)      begin n_bad++; $display("FAIL reset_wr got %b want 0", wr); end
    if (dest !== 5'd0)    begin n_bad++; $display("FAIL reset_dest got %0d want 0", dest); end
    if (result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [2:0]  f3v [12] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd2};
    logic [31:0] av  [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                              32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFB,
                              32'hFFFFFFFB, 32'hFFFFFFFF};
    logic [31:0] bv  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'd0, 32'd0, 32'd2, 32'd2, 32'd0, 32'd0,
                              32'hFFFFFFFF};
    logic [31:0] ev  [12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'h80000000,
                              32'h00000000, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFFD,
                              32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF};
    logic [31:0] res;
    logic        w;
    logic [4:0]  d;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      do_op(f3v[i], 5'(i + 3), av[i], bv[i], res, w, d, lat);
      n_cmp += 4;
      if (res !== ev[i]) begin n_bad++; $display("FAIL dir_result[%0d] got %h want %h", i, res, ev[i]); end
      if (lat != exp_lat(f3v[i])) begin n_bad++; $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, exp_lat(f3v[i])); end
      if (w !== 1'b1) begin n_bad++; $display("FAIL dir_wr[%0d] got %b want 1", i, w); end
      if (d !== 5'(i + 3)) begin n_bad++; $display("FAIL dir_dest[%0d] got %0d want %0d", i, d, i + 3); end
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_done got %b want 0", busy); end
  endtask

  task automatic test_random();
    logic [31:0] pool [4] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h1};
    logic [31:0] a, b, res, exp;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        w;
    logic [4:0]  d;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      rd = 5'($urandom_range(1, 31));
      a  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      exp = ref_m(f3, a, b);
      do_op(f3, rd, a, b, res, w, d, lat);
      n_cmp += 4;
      if (res !== exp) begin n_bad++; $display("FAIL rnd_result f3=%0d a=%h b=%h got %h want %h", f3, a, b, res, exp); end
      if (lat != exp_lat(f3)) begin n_bad++; $display("FAIL rnd_latency f3=%0d got %0d want %0d", f3, lat, exp_lat(f3)); end
      if (w !== 1'b1) begin n_bad++; $display("FAIL rnd_wr got %b want 1", w); end
      if (d !== rd) begin n_bad++; $display("FAIL rnd_dest got %0d want %0d", d, rd); end
    end
  endtask

  task automatic test_rd_zero();
    logic [31:0] res;
    logic        w;
    logic [4:0]  d;
    int          lat;
    do_op(3'd0, 5'd0, 32'd6, 32'd7, res, w, d, lat);
    n_cmp += 4;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL rd0_ready got %b want 1", ready); end
    if (w !== 1'b0) begin n_bad++; $display("FAIL rd0_wr got %b want 0", w); end
    if (d !== 5'd0) begin n_bad++; $display("FAIL rd0_dest got %0d want 0", d); end
    if (res !== 32'd42) begin n_bad++; $display("FAIL rd0_result got %h want 2a", res); end
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    @(negedge clk);
    instruction = mk_instr(3'd4, 5'd9); op1 = 32'd1000; op2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_busy_before got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy_after got %b want 0", busy); end
    repeat (40) begin
      @(negedge clk);
      if (ready || wr) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL flush_no_ready got ready=1 want never"); end
  endtask

  task automatic test_flush_start();
    @(negedge clk);
    instruction = mk_instr(3'd0, 5'd4); op1 = 32'd3; op2 = 32'd3;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_start_busy got %b want 0", busy); end
  endtask

  task automatic test_flush_done();
    logic [31:0] res;
    logic        w;
    logic [4:0]  d;
    int          lat;
    do_op(3'd5, 5'd12, 32'd91, 32'd7, res, w, d, lat);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp += 3;
    if (res !== 32'd13) begin n_bad++; $display("FAIL flush_done_result got %h want d", res); end
    if (w !== 1'b1) begin n_bad++; $display("FAIL flush_done_wr got %b want 1", w); end
    if (result !== 32'd13) begin n_bad++; $display("FAIL flush_done_hold got %h want d", result); end
  endtask

  task automatic test_rst_mid();
    bit seen = 1'b0;
    @(negedge clk);
    instruction = mk_instr(3'd0, 5'd17); op1 = 32'd5; op2 = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp += 5;
    if (busy !== 1'b0)    begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (ready !== 1'b0)   begin n_bad++; $display("FAIL rstmid_ready got %b want 0", ready); end
    if (wr !== 1'b0)      begin n_bad++; $display("FAIL rstmid_wr got %b want 0", wr); end
    if (dest !== 5'd0)    begin n_bad++; $display("FAIL rstmid_dest got %0d want 0", dest); end
    if (result !== 32'd0) begin n_bad++; $display("FAIL rstmid_result got %h want 0", result); end
    repeat (40) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL rstmid_no_ready got ready=1 want never"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic        w;
    logic [4:0]  d;
    int          lat;
    do_op(3'd4, 5'd20, 32'hFFFFFF9C, 32'd7, res, w, d, lat);
    instruction = mk_instr(3'd6, 5'd21); op1 = 32'hFFFFFF9C; op2 = 32'd7; start = 1'b1;
    n_cmp++;
    if (res !== 32'hFFFFFFF2) begin n_bad++; $display("FAIL b2b_first got %h want fffffff2", res); end
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %b want 1", busy); end
    while (!ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_cmp += 3;
    if (lat != 33) begin n_bad++; $display("FAIL b2b_latency got %0d want 33", lat); end
    if (result !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL b2b_second got %h want fffffffe", result); end
    if (dest !== 5'd21) begin n_bad++; $display("FAIL b2b_dest got %0d want 21", dest); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_rd_zero();
    test_flush();
    test_flush_start();
    test_flush_done();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
